sv_stream_to_bus: RTL and testbench
===================================

Name: sv_stream_to_bus

Overview:
Stream-to-bus deserializer: the receiving end of the 8-bit vld/rdy byte stream produced by the bus-to-stream mux.
- Collects N consecutive stream bytes into one address/data bus transfer.
- Presents that transfer on a vld/rdy bus output.
- Sits inside the mux/demux wrapper between sti_* and bso_*.
- Sustains one frame per N cycles when the bus sink is always ready.

Parameters:
AW, 32, address width; must be a multiple of SW
DW, 32, data width; must be a multiple of SW
SW, 8, stream byte width
TMO, 256, idle cycles before a partial frame is discarded (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock, asynchronous, active-low
sti_vld  input  1  stream byte valid
sti_bus  input  SW  stream byte
sti_rdy  output  1  stream ready
bso_vld  output  1  bus valid
bso_adr  output  AW  bus address
bso_dat  output  DW  bus data
bso_rdy  input  1  bus ready
frm_err  output  1  one-cycle pulse: partial frame discarded

Behaviour:
- Frame size and transfers
  - N = (AW+DW)/SW bytes per frame; 8 with defaults.
  - A stream transfer occurs when sti_vld & sti_rdy.
  - A bus transfer occurs when bso_vld & bso_rdy.
- Byte order
  - Byte k of a frame fills bits [k*SW +: SW] of the packed frame {dat, adr}.
  - With defaults, bytes 0-3 are the address LSB first and bytes 4-7 are the data LSB first.
- Assembly
  - Byte counter cnt runs 0..N-1 and increments on each stream transfer.
  - Bytes 0..N-2 are written into an assembly register.
- Last byte (cnt==N-1, stream transfer)
  - The assembly register plus the current byte load into bso_adr/bso_dat.
  - bso_vld<=1 and cnt<=0.
  - Latency: bso_vld is high from the clock edge that accepts the last byte.
- Ready
  - sti_rdy = (cnt!=N-1) | ~bso_vld | bso_rdy.
  - sti_rdy is combinational from bso_rdy.
  - Bytes 0..N-2 are always accepted.
  - The last byte stalls only while the output register holds an untaken transfer.
- Output hold
  - bso_vld clears on a bus transfer, unless a new frame loads in the same cycle, in which case it stays 1 with the new values.
  - While bso_vld=1 and bso_rdy=0, bso_adr/bso_dat/bso_vld are held stable.
- Simultaneous events: a bus transfer and a last-byte load in the same cycle give zero-bubble throughput.
- Reset (rst=0, asynchronous)
  - cnt=0, assembly register=0, bso_vld=0, bso_adr=0, bso_dat=0, frm_err=0.
  - Any partial frame is lost.
  - Resumes on the first clk edge after rst deasserts; no reset-exit handshake.
- Wrap-around: cnt returns to 0 after N-1; addresses are passed through unchanged, with no arithmetic.
- Idle stream: with sti_vld=0, state is frozen indefinitely unless the optional feature is enabled.

Optional Feature:
SV_STREAM_TO_BUS_TIMEOUT_EN
- Defined:
  - An idle counter clears on every stream transfer or when cnt==0.
  - It increments on each cycle with cnt!=0 and no stream transfer.
  - On reaching TMO-1: cnt<=0, the partial frame is discarded, and frm_err pulses for exactly one cycle.
  - bso_* are unaffected; a pending output stays valid.
  - Counter width is $clog2(TMO); it resets to 0.
- Not defined: no idle counter exists, frm_err is tied to 0, and partial frames wait forever.

Decomposition:
- Shared package sv_bus_mux_demux_pkg holds:
  - default AW/DW/SW;
  - localparam N;
  - the packed struct frame_t {dat, adr}, used by both mux and demux so the byte order is defined once.
- One sub-module, sv_stream_to_bus_tmo, holds the idle counter; it is instantiated only under the macro.

Test Plan:
- Back-to-back frames: after reset, stream bytes 00,00,00,00,78,56,34,12 then 01,00,00,00,EF,BE,AD,DE with bso_rdy=1.
  - Required: bso adr=0 dat=12345678, then adr=1 dat=DEADBEEF, each bso_vld 1 cycle.
  - Required: sti_rdy never low; frames 8 cycles apart.
- Output backpressure: bso_rdy=0 while a second frame streams in.
  - Required: bytes 0-6 accepted; sti_rdy=0 at byte 7; first frame held stable.
  - Then raise bso_rdy: both transfers occur in consecutive cycles, in order.
- Random gaps: random sti_vld gaps and random bso_rdy over 10 frames.
  - Required: output sequence equals input sequence; no loss or duplication.
- Async reset: assert rst=0 after byte 3 of a frame, then send a full fresh frame.
  - Required: bso_vld=0 immediately on reset; next output is the fresh frame only.
- Timeout (macro on, TMO=16): send 3 bytes, idle 15 cycles.
  - Required: frm_err pulses once, cnt=0; the next 8 bytes produce a correct frame.
  - Macro off: frm_err stays 0 and the frame completes with the next 5 bytes.

Source files
------------

// File: rtl/sv_bus_mux_demux_pkg.sv
// Shared definitions for the bus/stream mux-demux pair.
// Frame byte order lives here so both ends agree on it.
package sv_bus_mux_demux_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_SW = 8;
    localparam int N      = (DEF_AW + DEF_DW) / DEF_SW;

    // Byte k of a frame occupies bits [k*SW +: SW]; adr comes first on the wire.
    typedef struct packed {
        logic [DEF_DW-1:0] dat;
        logic [DEF_AW-1:0] adr;
    } frame_t;

endpackage

// File: rtl/sv_stream_to_bus_tmo.sv
// Idle watchdog for sv_stream_to_bus: discards a stalled partial frame.
// Only instantiated when SV_STREAM_TO_BUS_TIMEOUT_EN is defined.
module sv_stream_to_bus_tmo #(
    parameter int TMO = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic xfer,
    output logic flush,
    output logic frm_err
);

    localparam int IW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [IW-1:0] idle;

    // Fire on the edge where the idle count would reach TMO-1.
    assign flush = busy & ~xfer & (idle == IW'(TMO - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle    <= '0;
            frm_err <= 1'b0;
        end else begin
            frm_err <= flush;
            if (xfer | ~busy | flush) begin
                idle <= '0;
            end else begin
                idle <= idle + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sv_stream_to_bus.sv
// Stream-to-bus deserializer: N stream bytes -> one adr/dat bus transfer.
// Optional idle timeout: define SV_STREAM_TO_BUS_TIMEOUT_EN.
module sv_stream_to_bus
    import sv_bus_mux_demux_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int SW  = DEF_SW,
    parameter int TMO = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sti_vld,
    input  logic [SW-1:0] sti_bus,
    output logic          sti_rdy,
    output logic          bso_vld,
    output logic [AW-1:0] bso_adr,
    output logic [DW-1:0] bso_dat,
    input  logic          bso_rdy,
    output logic          frm_err
);

    localparam int FW = AW + DW;
    localparam int NB = FW / SW;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    if ((AW % SW) != 0 || (DW % SW) != 0) begin : g_width_chk
        $error("AW and DW must be multiples of SW");
    end
    if (TMO < 2) begin : g_tmo_chk
        $error("TMO must be at least 2");
    end

    logic [CW-1:0]    cnt;
    logic [FW-SW-1:0] asm_q;
    logic             last;
    logic             st_xfer;
    logic             load;
    logic             flush;
    logic             busy;

    assign last    = (cnt == LAST);
    assign sti_rdy = ~last | ~bso_vld | bso_rdy;
    assign st_xfer = sti_vld & sti_rdy;
    assign load    = st_xfer & last;
    assign busy    = (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (st_xfer) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // The final byte bypasses the assembly register straight into the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= '0;
        end else begin
            for (int k = 0; k < NB - 1; k++) begin
                if (st_xfer && cnt == CW'(k)) begin
                    asm_q[k*SW +: SW] <= sti_bus;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bso_vld <= 1'b0;
            bso_adr <= '0;
            bso_dat <= '0;
        end else if (load) begin
            bso_vld            <= 1'b1;
            {bso_dat, bso_adr} <= {sti_bus, asm_q};
        end else if (bso_rdy) begin
            bso_vld <= 1'b0;
        end
    end

`ifdef SV_STREAM_TO_BUS_TIMEOUT_EN
    sv_stream_to_bus_tmo #(
        .TMO (TMO)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .xfer    (st_xfer),
        .flush   (flush),
        .frm_err (frm_err)
    );
`else
    logic unused_busy;
    assign unused_busy = busy;
    assign flush       = 1'b0;
    assign frm_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sv_stream_to_bus.sv
// Directed testbench for sv_stream_to_bus.
// Covers both builds of the idle timeout option.
module tb_sv_stream_to_bus;
    import sv_bus_mux_demux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sti_vld = 1'b0;
    logic [7:0]  sti_bus = 8'h00;
    logic        sti_rdy;
    logic        bso_vld;
    logic [31:0] bso_adr;
    logic [31:0] bso_dat;
    logic        bso_rdy = 1'b0;
    logic        frm_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vld_cycles = 0;
    int err_cycles = 0;
    int rdy_low = 0;
    logic [63:0] got_q[$];
    int          got_t[$];

    sv_stream_to_bus #(
        .AW  (32),
        .DW  (32),
        .SW  (8),
        .TMO (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sti_vld (sti_vld),
        .sti_bus (sti_bus),
        .sti_rdy (sti_rdy),
        .bso_vld (bso_vld),
        .bso_adr (bso_adr),
        .bso_dat (bso_dat),
        .bso_rdy (bso_rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (bso_vld) vld_cycles++;
                if (frm_err) err_cycles++;
                if (sti_vld && !sti_rdy) rdy_low++;
                if (bso_vld && bso_rdy) begin
                    got_q.push_back({bso_dat, bso_adr});
                    got_t.push_back(cyc);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        sti_vld = 1'b1;
        sti_bus = b;
        do begin
            @(negedge clk);
            n++;
        end while (!sti_rdy && n < 200);
        checks++;
        if (sti_rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_byte: sti_rdy=%b required 1 within 200 cycles", sti_rdy);
        end
        @(posedge clk);
        #1;
        sti_vld = 1'b0;
    endtask

    task automatic send_bytes(input frame_t f, input int lo, input int hi);
        logic [63:0] v;
        v = f;
        for (int k = lo; k <= hi; k++) send_byte(v[k*8 +: 8]);
    endtask

    task automatic chk_frame(input string nm, input int idx, input frame_t exp);
        checks++;
        if (idx >= got_q.size()) begin
            errors++;
            $display("FAIL %s: no transfer observed, required %h", nm, exp);
        end else if (got_q[idx] !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got_q[idx], exp);
        end
    endtask

    task automatic chk_count(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #3;
        checks++;
        if (bso_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b required 0", bso_vld); end
        checks++;
        if (bso_adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h required 0", bso_adr); end
        checks++;
        if (bso_dat !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h required 0", bso_dat); end
        checks++;
        if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", frm_err); end
        checks++;
        if (sti_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b required 1", sti_rdy); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        frame_t a, b;
        int base, v0, r0;
        a = '{dat: 32'h12345678, adr: 32'h0};
        b = '{dat: 32'hDEADBEEF, adr: 32'h1};
        base = got_q.size();
        v0 = vld_cycles;
        r0 = rdy_low;
        bso_rdy = 1'b1;
        send_bytes(a, 0, 7);
        send_bytes(b, 0, 7);
        idle(3);
        chk_count("b2b_count", got_q.size() - base, 2);
        chk_frame("b2b_frame0", base, a);
        chk_frame("b2b_frame1", base + 1, b);
        if (got_q.size() >= base + 2)
            chk_count("b2b_spacing", got_t[base+1] - got_t[base], 8);
        chk_count("b2b_vld_cycles", vld_cycles - v0, 2);
        chk_count("b2b_rdy_low", rdy_low - r0, 0);
    endtask

    task automatic test_backpressure();
        frame_t c, d;
        logic [63:0] v;
        int base;
        c = '{dat: 32'hCAFE0001, adr: 32'h00000010};
        d = '{dat: 32'hCAFE0002, adr: 32'h00000020};
        base = got_q.size();
        bso_rdy = 1'b0;
        send_bytes(c, 0, 7);
        v = d;
        for (int k = 0; k < 7; k++) begin
            sti_vld = 1'b1;
            sti_bus = v[k*8 +: 8];
            @(negedge clk);
            checks++;
            if (sti_rdy !== 1'b1) begin
                errors++;
                $display("FAIL bp_byte%0d_rdy: got %b required 1", k, sti_rdy);
            end
            @(posedge clk);
            #1;
        end
        sti_vld = 1'b1;
        sti_bus = v[63:56];
        repeat (3) @(negedge clk);
        checks++;
        if (sti_rdy !== 1'b0) begin errors++; $display("FAIL bp_last_rdy: got %b required 0", sti_rdy); end
        checks++;
        if (bso_vld !== 1'b1) begin errors++; $display("FAIL bp_hold_vld: got %b required 1", bso_vld); end
        checks++;
        if ({bso_dat, bso_adr} !== c) begin
            errors++;
            $display("FAIL bp_hold_data: got %h required %h", {bso_dat, bso_adr}, c);
        end
        @(posedge clk);
        #1;
        bso_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (sti_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b required 1", sti_rdy); end
        @(posedge clk);
        #1;
        sti_vld = 1'b0;
        idle(3);
        chk_count("bp_count", got_q.size() - base, 2);
        chk_frame("bp_frame0", base, c);
        chk_frame("bp_frame1", base + 1, d);
        if (got_q.size() >= base + 2)
            chk_count("bp_spacing", got_t[base+1] - got_t[base], 1);
    endtask

    task automatic test_random_gaps();
        frame_t exp[10];
        int base, n;
        logic done;
        for (int i = 0; i < 10; i++) begin
            exp[i].adr = 32'h100 + 32'(i);
            exp[i].dat = $urandom;
        end
        base = got_q.size();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int k = 0; k < 8; k++) begin
                        n = $urandom_range(0, 2);
                        if (n > 0) idle(n);
                        send_bytes(exp[i], k, k);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bso_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        bso_rdy = 1'b1;
        idle(5);
        chk_count("rnd_count", got_q.size() - base, 10);
        for (int i = 0; i < 10; i++) chk_frame($sformatf("rnd_frame%0d", i), base + i, exp[i]);
    endtask

    task automatic test_async_reset();
        frame_t p, junk, f;
        int base;
        p    = '{dat: 32'h11112222, adr: 32'h000000AA};
        junk = '{dat: 32'hFFFFEEEE, adr: 32'hBAD00BAD};
        f    = '{dat: 32'h0BADF00D, adr: 32'h00000300};
        bso_rdy = 1'b0;
        send_bytes(p, 0, 7);
        send_bytes(junk, 0, 3);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bso_vld !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b required 0", bso_vld); end
        checks++;
        if ({bso_dat, bso_adr} !== 64'h0) begin
            errors++;
            $display("FAIL arst_data: got %h required 0", {bso_dat, bso_adr});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        base = got_q.size();
        bso_rdy = 1'b1;
        send_bytes(f, 0, 7);
        idle(3);
        chk_count("arst_count", got_q.size() - base, 1);
        chk_frame("arst_fresh", base, f);
    endtask

    task automatic test_timeout();
        frame_t e;
        int base, e0;
        e = '{dat: 32'h5555AAAA, adr: 32'h00000400};
        bso_rdy = 1'b1;
        base = got_q.size();
        e0 = err_cycles;
        send_bytes(e, 0, 2);
        idle(20);
`ifdef SV_STREAM_TO_BUS_TIMEOUT_EN
        begin
            frame_t g;
            g = '{dat: 32'h77778888, adr: 32'h00000500};
            chk_count("tmo_err_pulses", err_cycles - e0, 1);
            chk_count("tmo_no_output", got_q.size() - base, 0);
            send_bytes(g, 0, 7);
            idle(3);
            chk_count("tmo_count", got_q.size() - base, 1);
            chk_frame("tmo_frame", base, g);
        end
`else
        chk_count("tmo_err_pulses", err_cycles - e0, 0);
        chk_count("tmo_no_output", got_q.size() - base, 0);
        send_bytes(e, 3, 7);
        idle(3);
        chk_count("tmo_count", got_q.size() - base, 1);
        chk_frame("tmo_frame", base, e);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_random_gaps();
        test_async_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
